collect_usb_resp: RTL

Device-side responder for the console/collect USB command protocol. Accepts command bags (DCONF, DCONV, CLINK) from the packet parser and checks the device index. Drives the ADC configuration and conversion handshakes, then requests the packet builder to return the matching response bag (DTYPE, DTEMP, DATA). A link watchdog reports loss of the console's periodic CLINK keep-alive.

---
 rtl/collect_usb_resp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/collect_usb_resp.sv
// Device-side responder for the console/collect USB command protocol: accepts command bags,
// drives the ADC config/conversion handshakes, requests response bags and watches the CLINK keep-alive.
module collect_usb_resp #(
  parameter logic [31:0] LINK_TIMEOUT = 32'd15_000_000,
  parameter logic [31:0] DEVICE_IDX   = 32'h13579BDF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_read,
  output logic        fd_read,
  input  logic [3:0]  read_btype,
  input  logic [3:0]  read_data_idx,
  input  logic [31:0] read_device_idx,
  output logic        fs_conf,
  input  logic        fd_conf,
  output logic        fs_conv,
  input  logic        fd_conv,
  output logic        fs_send,
  input  logic        fd_send,
  output logic [3:0]  send_btype,
  output logic [3:0]  data_idx,
  output logic        link_ok,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] BAG_DCONF = 4'b0001;
  localparam logic [3:0] BAG_DCONV = 4'b1001;
  localparam logic [3:0] BAG_CLINK = 4'b1011;
  localparam logic [3:0] BAG_DTYPE = 4'b1001;
  localparam logic [3:0] BAG_DTEMP = 4'b1010;
  localparam logic [3:0] BAG_DATA  = 4'b0101;
  localparam logic [3:0] BAG_INIT  = 4'b0000;

  typedef enum logic [11:0] {
    MAIN_IDLE  = 12'b0000_0000_0001,
    TYPE_SEND  = 12'b0000_0000_0010,
    TYPE_DONE  = 12'b0000_0000_0100,
    MAIN_WAIT  = 12'b0000_0000_1000,
    READ_LATCH = 12'b0000_0001_0000,
    READ_DONE  = 12'b0000_0010_0000,
    CONF_WORK  = 12'b0000_0100_0000,
    CONF_DONE  = 12'b0000_1000_0000,
    CONV_WORK  = 12'b0001_0000_0000,
    CONV_DONE  = 12'b0010_0000_0000,
    RESP_SEND  = 12'b0100_0000_0000,
    RESP_DONE  = 12'b1000_0000_0000
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  btype_lat_reg, btype_lat_next;
  logic [3:0]  idx_lat_reg, idx_lat_next;
  logic [31:0] dev_lat_reg, dev_lat_next;
  logic [3:0]  send_btype_reg, send_btype_next;
  logic [3:0]  data_idx_reg, data_idx_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic [31:0] wd_cnt_reg, wd_cnt_next;
  logic        link_seen_reg, link_seen_next;

  logic cmd_known, cmd_accept, read_exit;

  assign cmd_known  = (btype_lat_reg == BAG_DCONF) || (btype_lat_reg == BAG_DCONV) ||
                      (btype_lat_reg == BAG_CLINK);
  assign cmd_accept = cmd_known && (dev_lat_reg == DEVICE_IDX);
  assign read_exit  = (state_reg == READ_DONE) && !fs_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= MAIN_IDLE;
      btype_lat_reg  <= 4'd0;
      idx_lat_reg    <= 4'd0;
      dev_lat_reg    <= 32'd0;
      send_btype_reg <= BAG_INIT;
      data_idx_reg   <= 4'd0;
      err_cnt_reg    <= 8'd0;
      wd_cnt_reg     <= 32'd0;
      link_seen_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      btype_lat_reg  <= btype_lat_next;
      idx_lat_reg    <= idx_lat_next;
      dev_lat_reg    <= dev_lat_next;
      send_btype_reg <= send_btype_next;
      data_idx_reg   <= data_idx_next;
      err_cnt_reg    <= err_cnt_next;
      wd_cnt_reg     <= wd_cnt_next;
      link_seen_reg  <= link_seen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MAIN_IDLE:  state_next = TYPE_SEND;
      TYPE_SEND:  if (fd_send)  state_next = TYPE_DONE;
      TYPE_DONE:  if (!fd_send) state_next = MAIN_WAIT;
      MAIN_WAIT:  if (fs_read)  state_next = READ_LATCH;
      READ_LATCH: state_next = READ_DONE;
      READ_DONE: begin
        if (!fs_read) begin
          if (cmd_accept && btype_lat_reg == BAG_DCONF)      state_next = CONF_WORK;
          else if (cmd_accept && btype_lat_reg == BAG_DCONV) state_next = CONV_WORK;
          else                                               state_next = MAIN_WAIT;
        end
      end
      CONF_WORK:  if (fd_conf)  state_next = CONF_DONE;
      CONF_DONE:  if (!fd_conf) state_next = RESP_SEND;
      CONV_WORK:  if (fd_conv)  state_next = CONV_DONE;
      CONV_DONE:  if (!fd_conv) state_next = RESP_SEND;
      RESP_SEND:  if (fd_send)  state_next = RESP_DONE;
      RESP_DONE:  if (!fd_send) state_next = MAIN_WAIT;
      default:    state_next = MAIN_IDLE;
    endcase
  end

  always_comb begin
    btype_lat_next  = btype_lat_reg;
    idx_lat_next    = idx_lat_reg;
    dev_lat_next    = dev_lat_reg;
    send_btype_next = send_btype_reg;
    data_idx_next   = data_idx_reg;
    err_cnt_next    = err_cnt_reg;
    link_seen_next  = link_seen_reg;
    wd_cnt_next     = (wd_cnt_reg < LINK_TIMEOUT) ? wd_cnt_reg + 32'd1 : wd_cnt_reg;

    if (state_reg == MAIN_WAIT && fs_read) begin
      btype_lat_next = read_btype;
      idx_lat_next   = read_data_idx;
      dev_lat_next   = read_device_idx;
    end
    if (state_reg == MAIN_IDLE) send_btype_next = BAG_DTYPE;
    if (state_reg == CONF_DONE && !fd_conf) send_btype_next = BAG_DTEMP;
    if (state_reg == CONV_DONE && !fd_conv) send_btype_next = BAG_DATA;

    // A clear on an accepted command overrides the saturating increment.
    if (read_exit) begin
      if (cmd_accept) begin
        wd_cnt_next    = 32'd0;
        link_seen_next = 1'b1;
        if (btype_lat_reg == BAG_DCONV) data_idx_next = idx_lat_reg;
      end else if (err_cnt_reg != 8'hFF) begin
        err_cnt_next = err_cnt_reg + 8'd1;
      end
    end
  end

  assign fd_read    = (state_reg == READ_DONE);
  assign fs_conf    = (state_reg == CONF_WORK);
  assign fs_conv    = (state_reg == CONV_WORK);
  assign fs_send    = (state_reg == TYPE_SEND) || (state_reg == RESP_SEND);
  assign send_btype = send_btype_reg;
  assign data_idx   = data_idx_reg;
  assign err_cnt    = err_cnt_reg;
  assign link_ok    = link_seen_reg && (wd_cnt_reg < LINK_TIMEOUT);

endmodule
